serial_mag_comparator: RTL

- Bit-serial, MSB-first magnitude comparator; the sequential counterpart to the team's combinational 2-bit comparator.
- Latches two WIDTH-bit operands on a start handshake, then resolves one bit pair per clock.
- Returns registered alb/aeb/agb flags with a one-cycle done pulse.
- Used where operand width makes a flat comparator too costly, or where operands already arrive registered.

---
 rtl/serial_mag_comparator.sv | 111 +++++++++++
 1 files changed

// File: rtl/serial_mag_comparator.sv
// Bit-serial MSB-first unsigned magnitude comparator: one bit pair per clock.
// Build option SERIAL_CMP_FIXED_LAT_EN: constant-time scan, done always after WIDTH compare edges.
module serial_mag_comparator #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             alb,
  output logic             aeb,
  output logic             agb
);

  typedef enum logic {IDLE, CMP} state_t;

  state_t           state;
  logic [WIDTH-1:0] ra, rb;
  logic [CNT_W-1:0] idx;
  logic             bit_gt, bit_lt;

  assign bit_gt = ra[idx] & ~rb[idx];
  assign bit_lt = ~ra[idx] & rb[idx];

`ifdef SERIAL_CMP_FIXED_LAT_EN
  // Sticky decision: the first differing bit wins, lower bits are still scanned
  // so that done timing never depends on operand values.
  logic dec_gt, dec_lt, nxt_gt, nxt_lt;
  assign nxt_gt = dec_gt | (~dec_lt & bit_gt);
  assign nxt_lt = dec_lt | (~dec_gt & bit_lt);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ra     <= '0;
      rb     <= '0;
      idx    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      alb    <= 1'b0;
      aeb    <= 1'b0;
      agb    <= 1'b0;
`ifdef SERIAL_CMP_FIXED_LAT_EN
      dec_gt <= 1'b0;
      dec_lt <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ra    <= a;
            rb    <= b;
            idx   <= CNT_W'(WIDTH-1);
            alb   <= 1'b0;
            aeb   <= 1'b0;
            agb   <= 1'b0;
            busy  <= 1'b1;
            state <= CMP;
`ifdef SERIAL_CMP_FIXED_LAT_EN
            dec_gt <= 1'b0;
            dec_lt <= 1'b0;
`endif
          end
        end
        CMP: begin
`ifdef SERIAL_CMP_FIXED_LAT_EN
          if (idx == '0) begin
            agb   <= nxt_gt;
            alb   <= nxt_lt;
            aeb   <= ~nxt_gt & ~nxt_lt;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            dec_gt <= nxt_gt;
            dec_lt <= nxt_lt;
            idx    <= idx - 1'b1;
          end
`else
          if (bit_gt) begin
            agb   <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (bit_lt) begin
            alb   <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (idx == '0) begin
            aeb   <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            idx <= idx - 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
